// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_MAX = 255;

  // funct3[1:0] carries the access size: 00 byte, 01 half, 1x word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: turns load/store control into a req/ack memory transaction
// and stalls until it completes. Define MEM_TIMEOUT_EN to abort requests after 255 cycles.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] ALUrslt_i,
  input  logic [DATA_W-1:0] WriteData_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        be_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              we_reg;
  logic [2:0]        f3_reg;
  logic [DATA_W-1:0] read_data_reg;
  logic              misalign_reg;

  logic              acc;
  logic              mis;
  logic              abort;
  logic [3:0]        be_calc;
  logic [DATA_W-1:0] wdata_calc;
  logic [DATA_W-1:0] load_data;

  assign acc = MemRead_i | MemWrite_i;
  assign mis = is_misaligned(funct3_i, ALUrslt_i[1:0]);

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   be_calc = 4'b0001 << ALUrslt_i[1:0];
      2'b01:   be_calc = 4'b0011 << ALUrslt_i[1:0];
      default: be_calc = 4'b1111;
    endcase
  end

  // Lane replication: every byte lane carries the byte/half that could land there.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_calc[gi*8 +: 8] =
        (funct3_i[1:0] == 2'b00) ? WriteData_i[7:0] :
        (funct3_i[1:0] == 2'b01) ? WriteData_i[(gi%2)*8 +: 8] :
                                   WriteData_i[gi*8 +: 8];
    end
  endgenerate

  mem_access_unit_load_extend u_load_extend (
    .rdata   (mem_rdata_i),
    .addr_lo (addr_reg[1:0]),
    .funct3  (f3_reg),
    .data    (load_data)
  );

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_reg;
  logic       timeout_reg;

  assign abort     = (state_reg == ST_REQ) && !mem_ack_i && (cnt_reg == 8'(TIMEOUT_MAX - 1));
  assign timeout_o = timeout_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg <= (state_reg == ST_REQ) ? cnt_reg + 8'd1 : 8'd0;
      if (abort)
        timeout_reg <= 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (acc) state_next = mis ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_ack_i || abort) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    case (state_reg)
      ST_IDLE: stall_o = acc;
      ST_REQ: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
      end
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_reg      <= '0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      f3_reg        <= '0;
      read_data_reg <= '0;
      misalign_reg  <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && acc) begin
        if (mis) begin
          misalign_reg  <= 1'b1;
          read_data_reg <= '0;
        end else begin
          addr_reg  <= ALUrslt_i;
          be_reg    <= be_calc;
          wdata_reg <= wdata_calc;
          we_reg    <= MemWrite_i & ~MemRead_i;
          f3_reg    <= funct3_i;
        end
      end else if (state_reg == ST_REQ) begin
        if (mem_ack_i && !we_reg)
          read_data_reg <= load_data;
        else if (abort)
          read_data_reg <= '0;
      end
    end
  end

  assign mem_we_o    = we_reg;
  assign mem_addr_o  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign mem_be_o    = be_reg;
  assign mem_wdata_o = wdata_reg;
  assign ReadData_o  = read_data_reg;
  assign misalign_o  = misalign_reg;

endmodule
